// File: rtl/clusterv_sram_initiator.sv
// Initiator for the tile's byte-enable SRAM target port: valid/ready word requests in,
// in-order responses out, with a zero-fill of the whole SRAM after reset or on demand.
module clusterv_sram_initiator #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_byte_en,
    input  logic [DATA_WIDTH-1:0]   req_write_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_read_data,
    input  logic                    clear_req,
    output logic                    clearing,
    output logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_write_en,
    output logic [DATA_WIDTH/8-1:0] i_byte_en,
    output logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic [DATA_WIDTH-1:0]   i_read_data
);
    localparam int unsigned BeW   = DATA_WIDTH / 8;
    localparam int unsigned WordW = ADDR_WIDTH - 2;
    localparam int unsigned PtrW  = $clog2(RSP_DEPTH);
    localparam int unsigned CntW  = $clog2(RSP_DEPTH + 1);
    localparam logic [CntW-1:0]  DepthCnt = CntW'(RSP_DEPTH);
    localparam logic [WordW-1:0] LastWord = {WordW{1'b1}};

    typedef enum logic [1:0] {StClearWait, StClear, StRun} state_e;
    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StRun;

    state_e             state_q, state_d;
    logic               clear_pend_q, clear_pend_d;
    logic [WordW-1:0]   word_q, word_d;
    logic [CntW-1:0]    out_q, out_d;

    logic [ADDR_WIDTH-1:0] port_addr_q, port_addr_d;
    logic [DATA_WIDTH-1:0] port_wdata_q, port_wdata_d;
    logic                  port_we_q, port_we_d;
    logic [BeW-1:0]        port_be_q, port_be_d;
    logic                  iss_valid_q, iss_valid_d;
    logic                  cap_valid_q, cap_valid_d;
    logic                  cap_write_q, cap_write_d;

    logic                  fifo_write_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q  [RSP_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic                  accept, pop, push, clr_active;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[1:0];

    assign rsp_valid     = (count_q != '0);
    assign rsp_write     = fifo_write_q[rd_ptr_q];
    assign rsp_read_data = fifo_data_q[rd_ptr_q];
    assign pop           = rsp_valid && rsp_ready;
    // A pop this cycle frees a credit, so a full pipeline can still accept.
    assign req_ready     = (state_q == StRun) && !clear_pend_q && ((out_q < DepthCnt) || pop);
    assign accept        = req_valid && req_ready;
    assign push          = cap_valid_q;
    assign push_data     = cap_write_q ? '0 : i_read_data;
    assign clearing      = (state_q != StRun) || clear_pend_q;

    // Clear writes drive the port directly; gating with reset keeps outputs quiet while held.
    assign clr_active   = (state_q == StClear) && !reset;
    assign i_addr       = clr_active ? {word_q, 2'b00} : port_addr_q;
    assign i_write_en   = clr_active || port_we_q;
    assign i_byte_en    = clr_active ? {BeW{1'b1}} : port_be_q;
    assign i_write_data = clr_active ? '0 : port_wdata_q;

    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q;
        word_d       = word_q;
        unique case (state_q)
            StRun: begin
                if (clear_req) begin
                    clear_pend_d = 1'b1;
                    state_d      = StClearWait;
                end
            end
            StClearWait: begin
                if (out_q == '0) begin
                    clear_pend_d = 1'b0;
                    state_d      = StClear;
                end
            end
            StClear: begin
                word_d = word_q + WordW'(1);
                if (word_q == LastWord) begin
                    state_d = StRun;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_comb begin
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;
        port_we_d    = 1'b0;
        port_be_d    = '0;
        iss_valid_d  = accept;
        cap_valid_d  = iss_valid_q;
        cap_write_d  = port_we_q;
        if (state_q == StClear) begin
            port_addr_d  = {word_q, 2'b00};
            port_wdata_d = '0;
        end else if (accept) begin
            port_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            port_wdata_d = req_write_data;
            port_we_d    = req_write;
            port_be_d    = req_write ? req_byte_en : '0;
        end
        out_d = out_q;
        if (accept && !pop) begin
            out_d = out_q + CntW'(1);
        end else if (!accept && pop) begin
            out_d = out_q - CntW'(1);
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ResetState;
            clear_pend_q <= 1'b0;
            word_q       <= '0;
            out_q        <= '0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
            port_we_q    <= 1'b0;
            port_be_q    <= '0;
            iss_valid_q  <= 1'b0;
            cap_valid_q  <= 1'b0;
            cap_write_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            word_q       <= word_d;
            out_q        <= out_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            port_we_q    <= port_we_d;
            port_be_q    <= port_be_d;
            iss_valid_q  <= iss_valid_d;
            cap_valid_q  <= cap_valid_d;
            cap_write_q  <= cap_write_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fifo_write_q[i] <= 1'b0;
                fifo_data_q[i]  <= '0;
            end
        end else if (push) begin
            fifo_write_q[wr_ptr_q] <= cap_write_q;
            fifo_data_q[wr_ptr_q]  <= push_data;
        end
    end

endmodule

// File: tb/tb_clusterv_sram_initiator.sv
// Bench for clusterv_sram_initiator: directed steps plus random traffic against a
// word-array reference model with an expected-response queue.
module tb_clusterv_sram_initiator;
    localparam int unsigned AW = 8;
    localparam int unsigned NW = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [3:0]  req_byte_en;
    logic [31:0] req_write_data;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_read_data;
    logic        clear_req, clearing;
    logic [7:0]  i_addr;
    logic        i_write_en;
    logic [3:0]  i_byte_en;
    logic [31:0] i_write_data, i_read_data;

    always #5 clock = ~clock;

    clusterv_sram_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .RSP_DEPTH(4), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_byte_en(req_byte_en), .req_write_data(req_write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_read_data(rsp_read_data), .clear_req(clear_req), .clearing(clearing),
        .i_addr(i_addr), .i_write_en(i_write_en), .i_byte_en(i_byte_en),
        .i_write_data(i_write_data), .i_read_data(i_read_data)
    );

    // SRAM target: registered address, read data one cycle later; seeded with non-zero junk.
    logic [31:0] sram [NW];
    logic [31:0] sram_rd_q;
    bit          sram_seeded = 1'b0;
    always @(posedge clock) begin
        if (!sram_seeded) begin
            for (int i = 0; i < NW; i++) sram[i] <= $urandom | 32'h1;
            sram_seeded <= 1'b1;
        end else if (i_write_en) begin
            for (int b = 0; b < 4; b++)
                if (i_byte_en[b]) sram[i_addr[7:2]][8*b +: 8] <= i_write_data[8*b +: 8];
        end
        sram_rd_q <= sram[i_addr[AW-1:2]];
    end
    assign i_read_data = sram_rd_q;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          first_acc_cyc = -1;
    int          first_pop_cyc = -1;
    int          last_pop_cyc = -1;
    bit          acc_seen;
    logic [31:0] last_rd;
    logic [31:0] model_mem [NW];
    logic [32:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic zero_model();
        for (int i = 0; i < NW; i++) model_mem[i] = 32'h0;
    endtask

    // Reference: every accepted request yields one response, answered in acceptance order.
    task automatic sample();
        logic [5:0]  idx;
        logic [32:0] e;
        if (rsp_valid && rsp_ready) begin
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            last_rd = rsp_read_data;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp", 64'({rsp_write, rsp_read_data}), 64'(e));
            end
        end
        if (req_valid && req_ready) begin
            n_acc++;
            acc_seen = 1'b1;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            idx = req_addr[7:2];
            if (req_write) begin
                for (int b = 0; b < 4; b++)
                    if (req_byte_en[b]) model_mem[idx][8*b +: 8] = req_write_data[8*b +: 8];
                exp_q.push_back({1'b1, 32'h0});
            end else begin
                exp_q.push_back({1'b0, model_mem[idx]});
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [3:0] be,
                          input logic [31:0] data);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_byte_en = be; req_write_data = data;
        acc_seen = 1'b0;
        while (!acc_seen && n < 50) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("req_accept", 64'(acc_seen), 64'(1));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_clear_done(input string tag);
        int n = 0;
        while (clearing && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(clearing), 64'(0));
    endtask

    initial begin
        int  acc0;
        int  n;
        bit  found;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_byte_en = '0; req_write_data = '0; rsp_ready = 1'b0; clear_req = 1'b0;
        zero_model();

        // Reset values
        repeat (3) @(posedge clock);
        #4;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp", 64'({rsp_valid, rsp_write, rsp_read_data}), 64'(0));
        check("rst_port", 64'({i_write_en, i_byte_en, i_addr, i_write_data}), 64'(0));
        check("rst_clearing", 64'(clearing), 64'(1));

        // Zero-fill after release: one word per cycle, 0x00..0xFC
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int w = 0; w < NW; w++) begin
            #3;
            check("clr_word",
                  64'({i_write_en, i_byte_en, i_addr, i_write_data, clearing, req_ready}),
                  64'({1'b1, 4'hF, 8'(w * 4), 32'h0, 1'b1, 1'b0}));
            tick();
        end
        #3;
        check("post_clr_ctrl", 64'({req_ready, clearing, i_write_en, i_byte_en}),
              64'({1'b1, 1'b0, 1'b0, 4'h0}));
        check("post_clr_addr_hold", 64'(i_addr), 64'(8'hFC));

        rsp_ready = 1'b1;
        do_req(1'b0, 8'h10, 4'h0, 32'h0);
        drain("drain_first");
        check("read_after_reset_clear", 64'(last_rd), 64'(0));

        // Full write, partial write, read-back
        do_req(1'b1, 8'h08, 4'hF, 32'hDEADBEEF);
        do_req(1'b1, 8'h0A, 4'h1, 32'h000000AA);
        do_req(1'b0, 8'h08, 4'h0, 32'h0);
        drain("drain_merge");
        check("merged_read", 64'(last_rd), 64'(32'hDEADBEAA));

        // Prefill every word with random data
        for (int i = 0; i < NW; i++) do_req(1'b1, 8'(i * 4), 4'hF, $urandom);
        drain("drain_prefill");

        // 16 back-to-back reads
        first_acc_cyc = -1; first_pop_cyc = -1; acc0 = n_acc;
        req_valid = 1'b1; req_write = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 8'($urandom);
            tick();
        end
        req_valid = 1'b0;
        check("b2b_accepts", 64'(n_acc - acc0), 64'(16));
        drain("drain_b2b");
        check("first_rsp_latency", 64'(first_pop_cyc - first_acc_cyc), 64'(3));
        check("rsp_per_cycle", 64'(last_pop_cyc - first_pop_cyc), 64'(15));

        // Credit limit with responses stalled
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; acc0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            req_addr = 8'($urandom);
            tick();
        end
        check("credit_accepts", 64'(n_acc - acc0), 64'(4));
        #3;
        check("credit_ready_low", 64'(req_ready), 64'(0));
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #3;
        check("ready_on_first_pop", 64'({rsp_valid, req_ready}), 64'(2'b11));
        drain("drain_credit");

        // Demand clear with two reads outstanding
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h08, 4'h0, 32'h0);
        do_req(1'b0, 8'h0C, 4'h0, 32'h0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        zero_model();
        #3;
        check("clr_req_ready_drop", 64'({req_ready, clearing}), 64'(2'b01));
        check("clr_wait_no_write", 64'(i_write_en), 64'(0));
        tick();
        #3;
        check("clr_wait_no_write2", 64'(i_write_en), 64'(0));
        drain("drain_pre_clear");
        wait_clear_done("demand_clear_done");
        do_req(1'b0, 8'h08, 4'h0, 32'h0);
        drain("drain_post_clear");
        check("read_after_demand_clear", 64'(last_rd), 64'(0));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr = 8'($urandom);
            req_byte_en = 4'($urandom);
            req_write_data = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 1'b0;
        drain("drain_random");

        // Reset in the middle of a clear, at word 20
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        zero_model();
        found = 1'b0; n = 0;
        while (!found && n < 200) begin
            #2;
            if (i_write_en && i_addr == 8'd80) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("reach_word20", 64'(found), 64'(1));
        reset = 1'b1;
        #1;
        check("midclr_rst_port", 64'({i_write_en, i_byte_en, i_addr, i_write_data}), 64'(0));
        check("midclr_rst_rsp", 64'({rsp_valid, req_ready, clearing}), 64'(3'b001));
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #3;
        check("clr_restart", 64'({i_write_en, i_byte_en, i_addr}), 64'({1'b1, 4'hF, 8'h00}));
        wait_clear_done("restart_clear_done");
        do_req(1'b0, 8'h50, 4'h0, 32'h0);
        drain("drain_final");
        check("read_after_restart", 64'(last_rd), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clusterv_sram_initiator.md
# clusterv_sram_initiator

Initiator-side driver for the tile's generic byte-enable SRAM target port: the other end of the interface the tile SRAM wrapper implements. It accepts word-granular read/write requests on a valid/ready channel and issues them to the SRAM port. It returns one in-order response per request on a valid/ready channel, and can zero-fill the whole SRAM after reset or on demand. It sits between the tile's load/store path and the tile SRAM wrapper.

## Interface
Parameters:
- ADDR_WIDTH, 8: byte address width on the SRAM port. NWORDS = 2^(ADDR_WIDTH-2).
- DATA_WIDTH, 32: fixed at 32. Byte-enable width is DATA_WIDTH/8 = 4.
- RSP_DEPTH, 4: maximum outstanding requests / response FIFO depth. Power of two, at least 2. A value of 4 or more gives full throughput.
- CLEAR_ON_RESET, 1: when 1, zero-fill runs automatically after reset.

Ports (clock and reset first):
- Clock and reset: one clock; reset is asynchronous and active-high (ports `clock`, `reset`).
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- req_byte_en  in  4  write byte lanes; ignored for reads.
- req_write_data  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echoes req_write of the request being answered.
- rsp_read_data  out  32  read data; 0 for write responses.
- clear_req  in  1  single-cycle pulse requesting a zero-fill.
- clearing  out  1  high while a zero-fill is pending or running.
- i_addr  out  ADDR_WIDTH  SRAM byte address; bits [1:0] are always 0.
- i_write_en  out  1  SRAM write strobe.
- i_byte_en  out  4  SRAM byte lanes.
- i_write_data  out  32  SRAM write data.
- i_read_data  in  32  SRAM read data. The target registers the address; data for the address driven in cycle C is valid in C+1.

## Operation
- State machine states: CLEAR_WAIT, CLEAR, RUN.
- After reset:
  - CLEAR_ON_RESET=1: enter CLEAR.
  - CLEAR_ON_RESET=0: enter RUN.
- In RUN, an accepted request is registered into the issue stage. The next cycle drives the SRAM port:
  - i_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}.
  - i_write_en = req_write.
  - i_byte_en = req_byte_en for writes, 0 for reads.
  - i_write_data = req_write_data.
- One cycle later the response is captured:
  - reads: i_read_data.
  - writes: 0.
- The captured response is pushed into the RSP_DEPTH-entry response FIFO. Responses leave strictly in request order.
- Outstanding counter: increments on request accept and decrements on response pop. Both in the same cycle leaves it unchanged.
- req_ready = (state==RUN) && !clear_pend && (outstanding < RSP_DEPTH), or the same condition evaluated with outstanding == RSP_DEPTH-1 when a pop happens this cycle. Requests are never dropped.
- Idle SRAM cycles: i_write_en=0 and i_byte_en=0; i_addr and i_write_data hold their last values.
- clear_req seen in RUN sets clear_pend:
  - req_ready drops the next cycle.
  - The state moves to CLEAR_WAIT.
  - CLEAR_WAIT waits until outstanding==0, i.e. all responses have been popped, then moves to CLEAR.
  - clear_req seen during CLEAR_WAIT or CLEAR is ignored.
- CLEAR: word counter w runs 0..NWORDS-1, one word per cycle:
  - i_addr = w<<2, i_write_en=1, i_byte_en=4'hF, i_write_data=0.
  - After word NWORDS-1 the state moves to RUN and the counter wraps to 0.
- clearing = (state != RUN) || clear_pend.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_write=0, rsp_read_data=0, i_addr=0, i_write_en=0, i_byte_en=0, i_write_data=0. Response FIFO empty, outstanding=0, w=0, clear_pend=0.
- clearing resets to CLEAR_ON_RESET.
- Accept in cycle N:
  - SRAM port driven in cycle N+1.
  - Read data sampled at the end of cycle N+2.
  - rsp_valid asserted in cycle N+3 at the earliest.
- Throughput: one request per cycle sustained while rsp_ready=1.
- FIFO full and push in the same cycle cannot occur; the credit check guarantees it.
- With FIFO empty, push and pop cannot occur in the same cycle, because the FIFO is registered. rsp_valid follows the push by one cycle.
- CLEAR takes exactly NWORDS cycles. req_ready may rise in the first cycle after the last clear write.
- Reset asserted mid-operation (including mid-CLEAR):
  - All outputs take their reset values immediately.
  - In-flight requests and responses are discarded.
  - On release, a zero-fill restarts at word 0 (if CLEAR_ON_RESET=1).

## Test plan
- Reset with ADDR_WIDTH=8 and CLEAR_ON_RESET=1, then release -> 64 consecutive writes at i_addr 0x00..0xFC with data 0 and byte_en F; clearing=1 throughout; req_ready rises the cycle after the 0xFC write; a read of 0x10 then returns 0.
- Write 0xDEADBEEF to 0x08 with byte_en F; write 0x000000AA to 0x0A with byte_en 0001; read 0x08 -> responses in order with rsp_write 1,1,0; read data 0xDEADBEAA.
- 16 back-to-back reads with rsp_ready=1 after prefill -> one response per cycle; the first rsp_valid arrives 3 cycles after the first accept.
- rsp_ready held low with req_valid held high -> exactly 4 accepts, then req_ready=0. Releasing rsp_ready -> 4 in-order responses, and req_ready returns the same cycle as the first pop.
- clear_req with 2 reads outstanding -> req_ready=0 the next cycle; both reads return pre-clear data; CLEAR starts after the second pop; a subsequent read returns 0.
- Assert reset during CLEAR at w=20 -> i_write_en=0 and rsp_valid=0 immediately; after release the clear restarts at i_addr 0x00.
